countdown_timer: RTL
====================

# countdown_timer

Loadable down-counting timer, the decrementing counterpart of the team's loadable up-counter. It counts a programmed period down to zero, flags terminal count, and optionally auto-reloads for periodic ticks. It is the standard period/timeout source for blocks that need "fire after N cycles" behaviour, and uses the same load/data interface as the up-counter.

## Interface
Parameters:
- WIDTH, 4, width of count, data and reload register

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- load  in  1  writes data into the count and reload registers; aborts any run
- data  in  WIDTH  period value captured on load
- start  in  1  begins (or restarts) a countdown from the reload register
- pause  in  1  freezes count while busy
- reload_en  in  1  auto-reload at terminal count instead of stopping
- count  out  WIDTH  current counter value
- busy  out  1  high in RUN and HOLD
- paused  out  1  high in HOLD
- tc  out  1  one-cycle terminal-count pulse
- done  out  1  level; high in DONE until the next load or start

## Operation
- Reset (rst_n low, asynchronous): state IDLE, count=0, reload_reg=0, busy=0, paused=0, tc=0, done=0.
- States: IDLE, RUN, HOLD, DONE. busy=(RUN|HOLD), paused=HOLD, done=DONE. All outputs are registered.
- Priority per edge: load > start > pause/decrement.
- load (any state): count<=data, reload_reg<=data, next state IDLE, tc<=0.
- start (any state, no load): if reload_reg!=0 then count<=reload_reg and state RUN. Otherwise count<=0, state DONE, tc<=1. start in RUN/HOLD restarts the period.
- RUN/HOLD, no load/start, pause=1: count holds, state HOLD.
- RUN/HOLD, no load/start, pause=0: state RUN and one decrement:
  - count>1: count<=count-1.
  - count==1 with reload_en=1: count<=reload_reg, tc<=1, stay RUN.
  - count==1 with reload_en=0: count<=0, tc<=1, state DONE.
- tc is high only on the cycle after the edge that produced it. It is forced 0 on all other edges.
- IDLE/DONE without load/start: count holds, no action; pause and reload_en are ignored.
- reload_en is sampled only at the count==1 decrement. It may change mid-run.
- Arithmetic is unsigned modulo-free: count never underflows, because 0 is reached only via the count==1 rule.
- Period: N=reload_reg cycles from the start edge to the tc edge, excluding paused cycles. Auto-reload gives a tc pulse every N unpaused cycles.

## Timing
- Latency: start sampled at edge E gives count=reload_reg after E, and tc/done after edge E+N (pause=0 throughout).
- Start with reload_reg=0: tc=1 and done=1 after edge E. No busy cycle.
- A pause on edge k suppresses exactly that edge's decrement. Each paused cycle extends the period by one.
- load and start on the same edge: load wins. The state goes to IDLE, and a further start is needed.
- start on the same edge as the count==1 decrement: start wins, count<=reload_reg, and no tc.
- rst_n asserted mid-run clears everything immediately, with no tc. Deassertion is synchronized externally.

## Structure
- Shared package countdown_timer_pkg: state enum typedef (IDLE, RUN, HOLD, DONE) and the WIDTH default constant.
- Single module. No sub-module is natural, because the FSM and datapath are tightly coupled.

## Test plan
- Reset: drive rst_n low mid-RUN (count=5) -> all outputs 0 asynchronously, before the next clk edge.
- One-shot: load data=3, start, reload_en=0 -> count 3,2,1,0. tc high one cycle after the third edge. done stays 1. busy drops with done.
- Auto-reload: load 4, reload_en=1, start, 12 cycles -> tc pulses every 4th cycle, count sequence 4,3,2,1,4,3..., done never asserts.
- Pause: load 5, start, pause high for 2 cycles after the first decrement -> paused=1 for 2 cycles, count frozen at 4, tc delayed to 7 cycles after start.
- Zero period: load 0, start -> next cycle tc=1, done=1, busy never 1.
- Collisions: load+start together -> IDLE with count=data. start on the count==1 edge -> count=reload_reg, no tc. load during HOLD -> IDLE, paused=0.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package countdown_timer_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter: counts the reload value to zero, pulses tc, optionally auto-reloads.
// All outputs are registered; load beats start, start beats pause/decrement.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             pause,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt, count_nxt;
  logic             tc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
      busy       <= (state_nxt == RUN) || (state_nxt == HOLD);
      paused     <= (state_nxt == HOLD);
      done       <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = data;
      reload_nxt = data;
      state_nxt  = IDLE;
    end else if (start) begin
      if (reload_reg != '0) begin
        count_nxt = reload_reg;
        state_nxt = RUN;
      end else begin
        count_nxt = '0;
        state_nxt = DONE;
        tc_nxt    = 1'b1;
      end
    end else if ((state == RUN) || (state == HOLD)) begin
      if (pause) begin
        state_nxt = HOLD;
      end else begin
        state_nxt = RUN;
        // Zero is only ever reached through the count==1 step, so no underflow.
        if (count > ONE) begin
          count_nxt = count - ONE;
        end else if (count == ONE) begin
          tc_nxt = 1'b1;
          if (reload_en) begin
            count_nxt = reload_reg;
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
      end
    end
  end

endmodule
